lsu_mem_stage: RTL and testbench
================================

# lsu_mem_stage

Load/store unit for the memory stage of the 3-stage RISC-V core. It consumes the execute→memory pipeline register outputs (ALU address, store data, access type) and drives a request/grant/response data bus with arbitrary wait states. It generates byte enables, aligns store data and sign- or zero-extends load data. It stalls the pipeline until the bus transaction completes.

## Interface
- DW, 32: data/address width; only 32 is supported.
- TIMEOUT, 16: maximum cycles spent in REQ+WAIT before a bus error is declared (range 2..255).

- clk_i  in  1  clock, rising edge.
- rst_i  in  1  synchronous, active-high reset.
- mem_read_m  in  1  load in memory stage.
- mem_write_m  in  1  store in memory stage; has priority if both are high.
- funct3_m  in  3  access type: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; stores use 000 SB, 001 SH, 010 SW; other codes are treated as word.
- alu_out_m  in  DW  byte address.
- write_data_m  in  DW  store data, right-aligned.
- load_data_m  out  DW  extended load result; valid when lsu_done_o=1.
- lsu_stall_o  out  1  holds all upstream pipeline registers.
- lsu_done_o  out  1  one-cycle pulse on access completion.
- bus_err_o  out  1  one-cycle pulse on timeout.
- misalign_o  out  1  one-cycle pulse on a misaligned access (see Configuration).
- dbus_req_o  out  1  request.
- dbus_we_o  out  1  write enable.
- dbus_addr_o  out  DW  word-aligned address ({addr[31:2],2'b00}).
- dbus_be_o  out  4  byte enables.
- dbus_wdata_o  out  DW  lane-aligned store data.
- dbus_gnt_i  in  1  grant; sampled only while in REQ.
- dbus_rvalid_i  in  1  response/ack for both loads and stores; sampled only in WAIT.
- dbus_rdata_i  in  DW  read data; valid with dbus_rvalid_i.

## Operation
- FSM states:
  - IDLE: if mem_read_m|mem_write_m, latch addr[1:0], funct3 and we; register the dbus outputs; go to REQ.
  - REQ: dbus_req_o=1; on dbus_gnt_i go to WAIT with dbus_req_o=0.
  - WAIT: on dbus_rvalid_i go to IDLE.
- Byte enables:
  - SB: be=1<<addr[1:0], wdata={4{wd[7:0]}}.
  - SH: be=addr[1]?1100:0011, wdata={2{wd[15:0]}}.
  - SW: be=1111, wdata=wd.
  - Loads: dbus_be_o=1111.
- Load data: select the byte/halfword using the latched addr[1:0], then sign-extend (LB/LH) or zero-extend (LBU/LHU). Stores and errors return load_data_m=0.
- Timeout counter: cleared in IDLE, increments each cycle in REQ/WAIT. When the count reaches TIMEOUT-1 without completion:
  - bus_err_o pulses and lsu_done_o pulses.
  - load_data_m=0, dbus_req_o drops, FSM returns to IDLE.
- dbus_rvalid_i seen in IDLE or REQ is ignored (no stray completion).
- Reset values: state IDLE, all dbus outputs 0, counter 0, all pulses 0, load_data_m 0.
- Reset mid-transaction abandons the access. A later rvalid is ignored.

## Timing
- lsu_stall_o=1 combinationally in IDLE while an access is presented, and throughout REQ and WAIT.
- lsu_stall_o=0 in the cycle dbus_rvalid_i is sampled in WAIT (or on timeout). The memory→writeback register captures load_data_m at that edge.
- Minimum occupancy with zero-wait bus: 3 cycles (IDLE detect, REQ+gnt, WAIT+rvalid); 2 stall cycles.
- A back-to-back access presented in the cycle after completion starts immediately from IDLE.
- dbus_* outputs are registered and stable from REQ entry until the grant edge.
- dbus_gnt_i and dbus_rvalid_i in the same cycle: only the gnt is honoured; rvalid must come in a later cycle.

## Configuration
- LSU_MISALIGN_TRAP_EN defined:
  - Misaligned LH/LHU/SH (addr[0]=1) or LW/SW (addr[1:0]≠0) issues no bus request.
  - In the IDLE detect cycle: misalign_o=1, lsu_done_o=1, lsu_stall_o=0, load_data_m=0.
- Undefined:
  - misalign_o is tied 0.
  - Halfword accesses ignore addr[0]; word accesses ignore addr[1:0].
  - All accesses go to the bus.

## Test plan
- LW at 0x100, gnt after 2 cycles, rvalid 1 cycle later with rdata 0xDEADBEEF -> dbus_addr_o=0x100, be=1111; load_data_m=0xDEADBEEF with lsu_done_o; stall high for exactly 4 cycles.
- LB at 0x203, rdata 0x80FF1122 -> be=1111, load_data_m=0xFFFFFF80; same access as LBU -> 0x00000080.
- SH at 0x102, wd=0x0000ABCD -> dbus_we_o=1, be=1100, wdata=0xABCDABCD, addr=0x100; lsu_done_o on ack.
- Load with no rvalid, TIMEOUT=16 -> bus_err_o pulses 16 cycles after REQ entry, stall drops, FSM returns to IDLE; a later rvalid is ignored.
- rst_i asserted in WAIT -> next cycle all outputs 0 and FSM in IDLE; a subsequent rvalid produces no lsu_done_o.
- With LSU_MISALIGN_TRAP_EN, LW at 0x101 -> misalign_o=1 and no dbus_req_o; without the macro -> bus access to 0x100, be=1111.

Source files
------------

// File: rtl/lsu_mem_stage.sv
// lsu_mem_stage: RISC-V memory-stage LSU on a req/gnt/rvalid bus; >=3 cycles per access, stalls upstream until rvalid or timeout.
// Define LSU_MISALIGN_TRAP_EN to complete misaligned half/word accesses in the detect cycle with misalign_o and no bus request.
module lsu_mem_stage #(
   parameter int DW      = 32,
   parameter int TIMEOUT = 16
) (
   input  logic          clk_i,
   input  logic          rst_i,
   input  logic          mem_read_m,
   input  logic          mem_write_m,
   input  logic [2:0]    funct3_m,
   input  logic [DW-1:0] alu_out_m,
   input  logic [DW-1:0] write_data_m,
   output logic [DW-1:0] load_data_m,
   output logic          lsu_stall_o,
   output logic          lsu_done_o,
   output logic          bus_err_o,
   output logic          misalign_o,
   output logic          dbus_req_o,
   output logic          dbus_we_o,
   output logic [DW-1:0] dbus_addr_o,
   output logic [3:0]    dbus_be_o,
   output logic [DW-1:0] dbus_wdata_o,
   input  logic          dbus_gnt_i,
   input  logic          dbus_rvalid_i,
   input  logic [DW-1:0] dbus_rdata_i
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_WAIT = 2'd2
   } state_t;

   localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

   state_t        r_state;
   logic [1:0]    r_off;
   logic [2:0]    r_funct3;
   logic          r_we;
   logic [7:0]    r_cnt;

   logic          w_access;
   logic          w_misal;
   logic          w_idle;
   logic          w_start;
   logic          w_trap;
   logic          w_complete;
   logic          w_timeout;
   logic [3:0]    w_be;
   logic [DW-1:0] w_wdata;
   logic [7:0]    w_byte;
   logic [15:0]   w_half;
   logic [DW-1:0] w_ext;

   assign w_access = mem_read_m | mem_write_m;
   assign w_idle   = (r_state == S_IDLE);

`ifdef LSU_MISALIGN_TRAP_EN
   logic w_is_byte;
   logic w_is_half;
   // Stores only know 000/001 as narrow; loads also have the unsigned 1xx forms.
   assign w_is_byte = mem_write_m ? (funct3_m == 3'b000) : (funct3_m[1:0] == 2'b00);
   assign w_is_half = mem_write_m ? (funct3_m == 3'b001) : (funct3_m[1:0] == 2'b01);
   assign w_misal   = w_is_half ? alu_out_m[0] : (!w_is_byte && (alu_out_m[1:0] != 2'b00));
`else
   assign w_misal   = 1'b0;
`endif

   assign w_start    = w_idle && w_access && !w_misal;
   assign w_trap     = w_idle && w_access && w_misal;
   assign w_complete = (r_state == S_WAIT) && dbus_rvalid_i;
   assign w_timeout  = !w_idle && (r_cnt == TO_LAST) && !w_complete;

   assign lsu_stall_o = w_start || (!w_idle && !w_complete && !w_timeout);
   assign lsu_done_o  = w_complete || w_timeout || w_trap;
   assign bus_err_o   = w_timeout;
   assign misalign_o  = w_trap;

   always_comb begin
      w_be    = 4'b1111;
      w_wdata = '0;
      if (mem_write_m) begin
         w_wdata = write_data_m;
         case (funct3_m)
            3'b000: begin
               w_be    = 4'b0001 << alu_out_m[1:0];
               w_wdata = {4{write_data_m[7:0]}};
            end
            3'b001: begin
               w_be    = alu_out_m[1] ? 4'b1100 : 4'b0011;
               w_wdata = {2{write_data_m[15:0]}};
            end
            default: ;
         endcase
      end
   end

   // Halfword lane ignores r_off[0]; misaligned halves never reach here when trapping.
   assign w_byte = dbus_rdata_i[{r_off, 3'b000} +: 8];
   assign w_half = r_off[1] ? dbus_rdata_i[31:16] : dbus_rdata_i[15:0];

   always_comb begin
      case (r_funct3)
         3'b000:  w_ext = {{24{w_byte[7]}}, w_byte};
         3'b100:  w_ext = {24'b0, w_byte};
         3'b001:  w_ext = {{16{w_half[15]}}, w_half};
         3'b101:  w_ext = {16'b0, w_half};
         default: w_ext = dbus_rdata_i;
      endcase
   end

   assign load_data_m = (w_complete && !r_we) ? w_ext : '0;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state      <= S_IDLE;
         r_off        <= 2'b00;
         r_funct3     <= 3'b000;
         r_we         <= 1'b0;
         r_cnt        <= 8'd0;
         dbus_req_o   <= 1'b0;
         dbus_we_o    <= 1'b0;
         dbus_addr_o  <= '0;
         dbus_be_o    <= 4'b0000;
         dbus_wdata_o <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               r_cnt <= 8'd0;
               if (w_start) begin
                  r_off        <= alu_out_m[1:0];
                  r_funct3     <= funct3_m;
                  r_we         <= mem_write_m;
                  dbus_req_o   <= 1'b1;
                  dbus_we_o    <= mem_write_m;
                  dbus_addr_o  <= {alu_out_m[DW-1:2], 2'b00};
                  dbus_be_o    <= w_be;
                  dbus_wdata_o <= w_wdata;
                  r_state      <= S_REQ;
               end
            end
            S_REQ: begin
               if (w_timeout) begin
                  dbus_req_o <= 1'b0;
                  r_cnt      <= 8'd0;
                  r_state    <= S_IDLE;
               end else if (dbus_gnt_i) begin
                  dbus_req_o <= 1'b0;
                  r_cnt      <= r_cnt + 8'd1;
                  r_state    <= S_WAIT;
               end else begin
                  r_cnt <= r_cnt + 8'd1;
               end
            end
            S_WAIT: begin
               if (w_complete || w_timeout) begin
                  r_cnt   <= 8'd0;
                  r_state <= S_IDLE;
               end else begin
                  r_cnt <= r_cnt + 8'd1;
               end
            end
            default: begin
               dbus_req_o <= 1'b0;
               r_cnt      <= 8'd0;
               r_state    <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_lsu_mem_stage.sv
// Directed bench for lsu_mem_stage: vector table of single accesses plus hand-written multi-cycle sequences.
module tb_lsu_mem_stage;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic        mem_read_m;
   logic        mem_write_m;
   logic [2:0]  funct3_m;
   logic [31:0] alu_out_m;
   logic [31:0] write_data_m;
   logic [31:0] load_data_m;
   logic        lsu_stall_o;
   logic        lsu_done_o;
   logic        bus_err_o;
   logic        misalign_o;
   logic        dbus_req_o;
   logic        dbus_we_o;
   logic [31:0] dbus_addr_o;
   logic [3:0]  dbus_be_o;
   logic [31:0] dbus_wdata_o;
   logic        dbus_gnt_i;
   logic        dbus_rvalid_i;
   logic [31:0] dbus_rdata_i;

   int n_tests = 0;
   int n_fail  = 0;

   lsu_mem_stage #(.DW(32), .TIMEOUT(16)) dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .mem_read_m(mem_read_m), .mem_write_m(mem_write_m), .funct3_m(funct3_m),
      .alu_out_m(alu_out_m), .write_data_m(write_data_m), .load_data_m(load_data_m),
      .lsu_stall_o(lsu_stall_o), .lsu_done_o(lsu_done_o), .bus_err_o(bus_err_o),
      .misalign_o(misalign_o), .dbus_req_o(dbus_req_o), .dbus_we_o(dbus_we_o),
      .dbus_addr_o(dbus_addr_o), .dbus_be_o(dbus_be_o), .dbus_wdata_o(dbus_wdata_o),
      .dbus_gnt_i(dbus_gnt_i), .dbus_rvalid_i(dbus_rvalid_i), .dbus_rdata_i(dbus_rdata_i)
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      logic        rd;
      logic        wr;
      logic [2:0]  f3;
      logic [31:0] addr;
      logic [31:0] wd;
      logic [31:0] rdata;
      int          g;
      int          r;
      logic        exp_we;
      logic [31:0] exp_addr;
      logic [3:0]  exp_be;
      logic [31:0] exp_wdata;
      logic [31:0] exp_load;
   } vec_t;

   vec_t vq[$];

   function automatic vec_t mk(input logic rd, input logic wr, input logic [2:0] f3,
                               input logic [31:0] addr, input logic [31:0] wd,
                               input logic [31:0] rdata, input int g, input int r,
                               input logic exp_we, input logic [31:0] exp_addr,
                               input logic [3:0] exp_be, input logic [31:0] exp_wdata,
                               input logic [31:0] exp_load);
      vec_t v;
      v.rd = rd; v.wr = wr; v.f3 = f3; v.addr = addr; v.wd = wd; v.rdata = rdata;
      v.g = g; v.r = r; v.exp_we = exp_we; v.exp_addr = exp_addr; v.exp_be = exp_be;
      v.exp_wdata = exp_wdata; v.exp_load = exp_load;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic drive(input logic rd, input logic wr, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wd);
      mem_read_m   = rd;
      mem_write_m  = wr;
      funct3_m     = f3;
      alu_out_m    = addr;
      write_data_m = wd;
   endtask

   task automatic idle_inputs();
      drive(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
   endtask

   task automatic run_vec(input int i, input vec_t v);
      int last;
      int n_stall;
      int n_done;
      int n_req;
      last = v.g + 2 + v.r;
      n_stall = 0; n_done = 0; n_req = 0;
      drive(v.rd, v.wr, v.f3, v.addr, v.wd);
      dbus_rdata_i = v.rdata;
      for (int c = 0; c <= last; c++) begin
         dbus_gnt_i    = (c == v.g + 1);
         dbus_rvalid_i = (c == last);
         @(negedge clk_i);
         if (lsu_stall_o) n_stall++;
         if (lsu_done_o)  n_done++;
         if (dbus_req_o)  n_req++;
         if (c == 0) chk($sformatf("v%0d_misalign", i), 32'(misalign_o), 32'd0);
         if (c == 1) begin
            chk($sformatf("v%0d_we", i),    32'(dbus_we_o),    32'(v.exp_we));
            chk($sformatf("v%0d_addr", i),  dbus_addr_o,        v.exp_addr);
            chk($sformatf("v%0d_be", i),    32'(dbus_be_o),    32'(v.exp_be));
            chk($sformatf("v%0d_wdata", i), dbus_wdata_o,       v.exp_wdata);
         end
         if (c == last) begin
            chk($sformatf("v%0d_done", i),  32'(lsu_done_o),   32'd1);
            chk($sformatf("v%0d_stall", i), 32'(lsu_stall_o),  32'd0);
            chk($sformatf("v%0d_err", i),   32'(bus_err_o),    32'd0);
            chk($sformatf("v%0d_load", i),  load_data_m,        v.exp_load);
         end
         tick();
      end
      idle_inputs();
      dbus_gnt_i = 1'b0;
      dbus_rvalid_i = 1'b0;
      @(negedge clk_i);
      chk($sformatf("v%0d_idle_req", i),  32'(dbus_req_o), 32'd0);
      chk($sformatf("v%0d_idle_done", i), 32'(lsu_done_o), 32'd0);
      chk($sformatf("v%0d_stall_cycles", i), 32'(n_stall), 32'(last));
      chk($sformatf("v%0d_done_pulses", i),  32'(n_done),  32'd1);
      chk($sformatf("v%0d_req_cycles", i),   32'(n_req),   32'(v.g + 1));
      tick();
   endtask

   task automatic run_timeout(input string nm, input int gnt_at);
      int err_c;
      int n_stall;
      err_c = -1;
      n_stall = 0;
      drive(1'b1, 1'b0, 3'b010, 32'h40, 32'h0);
      dbus_rdata_i = 32'h5555AAAA;
      for (int c = 0; c < 40 && err_c < 0; c++) begin
         dbus_gnt_i    = (c == gnt_at);
         dbus_rvalid_i = 1'b0;
         @(negedge clk_i);
         if (lsu_stall_o) n_stall++;
         if (bus_err_o) begin
            err_c = c;
            chk({nm, "_done"},  32'(lsu_done_o),  32'd1);
            chk({nm, "_stall"}, 32'(lsu_stall_o), 32'd0);
            chk({nm, "_load"},  load_data_m,       32'h0);
         end
         tick();
      end
      chk({nm, "_err_cycle"},    32'(err_c),   32'd16);
      chk({nm, "_stall_cycles"}, 32'(n_stall), 32'd16);
      idle_inputs();
      dbus_gnt_i    = 1'b0;
      dbus_rvalid_i = 1'b1;
      @(negedge clk_i);
      chk({nm, "_late_done"}, 32'(lsu_done_o), 32'd0);
      chk({nm, "_late_req"},  32'(dbus_req_o), 32'd0);
      chk({nm, "_late_err"},  32'(bus_err_o),  32'd0);
      tick();
      dbus_rvalid_i = 1'b0;
   endtask

   initial begin
      rst_i = 1'b1;
      idle_inputs();
      dbus_gnt_i = 1'b0;
      dbus_rvalid_i = 1'b0;
      dbus_rdata_i = 32'hFFFFFFFF;

      //      rd wr f3      addr          wd            rdata         g  r  we  exp_addr      be       wdata         load
      vq.push_back(mk(1, 0, 3'b010, 32'h00000100, 32'h0,        32'hDEADBEEF, 2, 0, 0, 32'h00000100, 4'b1111, 32'h0,        32'hDEADBEEF));
      vq.push_back(mk(1, 0, 3'b000, 32'h00000203, 32'h0,        32'h80FF1122, 0, 0, 0, 32'h00000200, 4'b1111, 32'h0,        32'hFFFFFF80));
      vq.push_back(mk(1, 0, 3'b100, 32'h00000203, 32'h0,        32'h80FF1122, 0, 0, 0, 32'h00000200, 4'b1111, 32'h0,        32'h00000080));
      vq.push_back(mk(0, 1, 3'b001, 32'h00000102, 32'h0000ABCD, 32'h12345678, 1, 1, 1, 32'h00000100, 4'b1100, 32'hABCDABCD, 32'h0));
      vq.push_back(mk(0, 1, 3'b000, 32'h00000001, 32'h123456A5, 32'h12345678, 0, 0, 1, 32'h00000000, 4'b0010, 32'hA5A5A5A5, 32'h0));
      vq.push_back(mk(0, 1, 3'b010, 32'h0000010C, 32'hCAFEF00D, 32'h0,        0, 2, 1, 32'h0000010C, 4'b1111, 32'hCAFEF00D, 32'h0));
      vq.push_back(mk(1, 0, 3'b001, 32'h00000002, 32'h0,        32'h80017FFE, 0, 0, 0, 32'h00000000, 4'b1111, 32'h0,        32'hFFFF8001));
      vq.push_back(mk(1, 0, 3'b101, 32'h00000002, 32'h0,        32'h80017FFE, 0, 0, 0, 32'h00000000, 4'b1111, 32'h0,        32'h00008001));
      vq.push_back(mk(1, 0, 3'b001, 32'h00000000, 32'h0,        32'h80017FFE, 0, 1, 0, 32'h00000000, 4'b1111, 32'h0,        32'h00007FFE));
      vq.push_back(mk(1, 0, 3'b000, 32'h00000001, 32'h0,        32'h11227F33, 1, 0, 0, 32'h00000000, 4'b1111, 32'h0,        32'h0000007F));
      vq.push_back(mk(1, 0, 3'b011, 32'h00000024, 32'h0,        32'h89ABCDEF, 0, 0, 0, 32'h00000024, 4'b1111, 32'h0,        32'h89ABCDEF));
      vq.push_back(mk(1, 1, 3'b000, 32'h00000003, 32'h0000005A, 32'hFFFFFFFF, 0, 0, 1, 32'h00000000, 4'b1000, 32'h5A5A5A5A, 32'h0));
`ifndef LSU_MISALIGN_TRAP_EN
      vq.push_back(mk(1, 0, 3'b010, 32'h00000101, 32'h0,        32'h01234567, 0, 0, 0, 32'h00000100, 4'b1111, 32'h0,        32'h01234567));
`endif

      tick();
      tick();
      @(negedge clk_i);
      chk("rst_req",   32'(dbus_req_o),  32'd0);
      chk("rst_we",    32'(dbus_we_o),   32'd0);
      chk("rst_addr",  dbus_addr_o,       32'h0);
      chk("rst_be",    32'(dbus_be_o),   32'd0);
      chk("rst_wdata", dbus_wdata_o,      32'h0);
      chk("rst_done",  32'(lsu_done_o),  32'd0);
      chk("rst_err",   32'(bus_err_o),   32'd0);
      chk("rst_load",  load_data_m,       32'h0);
      chk("rst_stall", 32'(lsu_stall_o), 32'd0);
      tick();
      rst_i = 1'b0;

      foreach (vq[i]) run_vec(i, vq[i]);

      run_timeout("to_req", -1);
      run_timeout("to_wait", 1);

      // Reset while waiting for a store ack; the late ack must be ignored.
      drive(1'b0, 1'b1, 3'b010, 32'h84, 32'h11111111);
      @(negedge clk_i); tick();
      dbus_gnt_i = 1'b1;
      @(negedge clk_i); tick();
      dbus_gnt_i = 1'b0;
      rst_i = 1'b1;
      idle_inputs();
      @(negedge clk_i); tick();
      rst_i = 1'b0;
      @(negedge clk_i);
      chk("wrst_req",   32'(dbus_req_o),  32'd0);
      chk("wrst_we",    32'(dbus_we_o),   32'd0);
      chk("wrst_addr",  dbus_addr_o,       32'h0);
      chk("wrst_be",    32'(dbus_be_o),   32'd0);
      chk("wrst_wdata", dbus_wdata_o,      32'h0);
      chk("wrst_stall", 32'(lsu_stall_o), 32'd0);
      chk("wrst_done",  32'(lsu_done_o),  32'd0);
      tick();
      dbus_rvalid_i = 1'b1;
      @(negedge clk_i);
      chk("wrst_late_done", 32'(lsu_done_o), 32'd0);
      chk("wrst_late_load", load_data_m,      32'h0);
      tick();
      dbus_rvalid_i = 1'b0;

      // rvalid in IDLE and together with gnt is not a completion.
      drive(1'b1, 1'b0, 3'b010, 32'h10, 32'h0);
      dbus_rdata_i = 32'h0BADF00D;
      dbus_rvalid_i = 1'b1;
      @(negedge clk_i);
      chk("same_c0_done", 32'(lsu_done_o), 32'd0);
      tick();
      dbus_gnt_i = 1'b1;
      @(negedge clk_i);
      chk("same_c1_done",  32'(lsu_done_o),  32'd0);
      chk("same_c1_stall", 32'(lsu_stall_o), 32'd1);
      tick();
      dbus_gnt_i = 1'b0;
      dbus_rvalid_i = 1'b0;
      @(negedge clk_i);
      chk("same_c2_done",  32'(lsu_done_o),  32'd0);
      chk("same_c2_stall", 32'(lsu_stall_o), 32'd1);
      tick();
      dbus_rvalid_i = 1'b1;
      @(negedge clk_i);
      chk("same_c3_done", 32'(lsu_done_o), 32'd1);
      chk("same_c3_load", load_data_m,      32'h0BADF00D);
      tick();
      dbus_rvalid_i = 1'b0;

      // Back-to-back: next access presented in the cycle after completion.
      drive(1'b0, 1'b1, 3'b010, 32'h30, 32'hA5A50000);
      @(negedge clk_i);
      chk("b2b_detect_stall", 32'(lsu_stall_o), 32'd1);
      chk("b2b_detect_done",  32'(lsu_done_o),  32'd0);
      tick();
      dbus_gnt_i = 1'b1;
      @(negedge clk_i);
      chk("b2b_req",  32'(dbus_req_o), 32'd1);
      chk("b2b_we",   32'(dbus_we_o),  32'd1);
      chk("b2b_addr", dbus_addr_o,      32'h30);
      tick();
      dbus_gnt_i = 1'b0;
      dbus_rvalid_i = 1'b1;
      @(negedge clk_i);
      chk("b2b_done", 32'(lsu_done_o), 32'd1);
      chk("b2b_load", load_data_m,      32'h0);
      tick();
      dbus_rvalid_i = 1'b0;
      idle_inputs();

`ifdef LSU_MISALIGN_TRAP_EN
      drive(1'b1, 1'b0, 3'b010, 32'h101, 32'h0);
      @(negedge clk_i);
      chk("mis_flag",  32'(misalign_o),  32'd1);
      chk("mis_done",  32'(lsu_done_o),  32'd1);
      chk("mis_stall", 32'(lsu_stall_o), 32'd0);
      chk("mis_load",  load_data_m,       32'h0);
      tick();
      idle_inputs();
      @(negedge clk_i);
      chk("mis_no_req",  32'(dbus_req_o), 32'd0);
      chk("mis_pulse",   32'(misalign_o), 32'd0);
      tick();
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
